cpu_sequencer: RTL

Command initiator for the 8-bit CPU core's load/operate interface. The sequencer stores a short program of CPU commands written by a host, then, on `start`, replays them into the CPU's `ce`/`load`/`opcode`/`data_in`/`cin` inputs. It respects the CPU's one-cycle load and two-cycle operate timing, and captures the accumulator (`data_out`, register 0) and `cout` after every operate command. It sits between the host/test logic and the CPU core and is the only driver of the CPU command port.

---
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Stores a short CPU command program and replays it into the CPU load/operate port,
// capturing the accumulator and carry after each operate command.
module cpu_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [16:0]       prog_data,
  input  logic              prog_clr,
  output logic [ADDR_W:0]   prog_count,
  output logic              prog_full,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cpu_ce,
  output logic              cpu_load,
  output logic              cpu_cin,
  output logic [6:0]        cpu_opcode,
  output logic [7:0]        cpu_data,
  input  logic [7:0]        cpu_data_out,
  input  logic              cpu_cout,
  output logic [7:0]        result,
  output logic              result_cout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, FINISH} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;

  logic [16:0] mem [DEPTH];

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n, idx_inc;
  logic [ADDR_W:0]   wptr_n;
  logic              last;
  logic              issue;
  logic [16:0]       issue_word;
  logic              ce_n, load_n, cin_n;
  logic [6:0]        opcode_n;
  logic [7:0]        data_n, result_n;
  logic              result_cout_n;
  logic              mem_we;

  assign idx_inc = idx + IDX_ONE;
  assign last    = (({1'b0, idx} + CNT_ONE) == prog_count);

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    wptr_n        = prog_count;
    mem_we        = 1'b0;
    issue         = 1'b0;
    issue_word    = mem[idx_inc];
    result_n      = result;
    result_cout_n = result_cout;

    case (state)
      IDLE: begin
        if (prog_clr) begin
          wptr_n = '0;
        end else if (prog_we && !prog_full) begin
          wptr_n = prog_count + CNT_ONE;
          mem_we = 1'b1;
        end
        if (start) begin
          if (prog_count == '0) begin
            state_n = FINISH;
          end else begin
            idx_n      = '0;
            issue      = 1'b1;
            issue_word = mem[0];
            state_n    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!cpu_load) begin
          state_n = WAIT;
        end else if (last) begin
          state_n = FINISH;
        end else begin
          idx_n   = idx_inc;
          issue   = 1'b1;
          state_n = ISSUE;
        end
      end
      WAIT: state_n = CAPTURE;
      CAPTURE: begin
        result_n      = cpu_data_out;
        result_cout_n = cpu_cout;
        if (last) begin
          state_n = FINISH;
        end else begin
          idx_n   = idx_inc;
          issue   = 1'b1;
          state_n = ISSUE;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Command fields hold their previous values whenever no command is issued.
    ce_n     = issue;
    load_n   = issue ? issue_word[15]   : cpu_load;
    cin_n    = issue ? issue_word[16]   : cpu_cin;
    opcode_n = issue ? issue_word[14:8] : cpu_opcode;
    data_n   = issue ? issue_word[7:0]  : cpu_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      prog_count  <= '0;
      prog_full   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cpu_ce      <= 1'b0;
      cpu_load    <= 1'b0;
      cpu_cin     <= 1'b0;
      cpu_opcode  <= '0;
      cpu_data    <= '0;
      result      <= '0;
      result_cout <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      prog_count  <= wptr_n;
      prog_full   <= (wptr_n == FULL_CNT);
      busy        <= (state_n != IDLE);
      done        <= (state_n == FINISH);
      cpu_ce      <= ce_n;
      cpu_load    <= load_n;
      cpu_cin     <= cin_n;
      cpu_opcode  <= opcode_n;
      cpu_data    <= data_n;
      result      <= result_n;
      result_cout <= result_cout_n;
    end
  end

  // Program storage needs no reset; only the write pointer defines valid entries.
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[prog_count[ADDR_W-1:0]] <= prog_data;
  end

endmodule
